// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing a single-port, 1-cycle-latency instruction memory
// between the core fetch port (m0) and the loader/debug port (m1), with in-order responses.
module imem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req_valid,
  output logic          m0_req_ready,
  input  logic [AW-1:0] m0_addr,
  output logic          m0_rsp_valid,
  input  logic          m0_rsp_ready,
  output logic [DW-1:0] m0_rsp_data,
  input  logic          m1_req_valid,
  output logic          m1_req_ready,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_rsp_valid,
  input  logic          m1_rsp_ready,
  output logic [DW-1:0] m1_rsp_data,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic          a_valid_q, a_valid_d;
  logic          a_owner_q, a_owner_d;
  logic          a_we_q, a_we_d;
  logic          fifo_owner_q [2];
  logic          fifo_owner_d [2];
  logic [DW-1:0] fifo_data_q [2];
  logic [DW-1:0] fifo_data_d [2];
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          last_grant_q, last_grant_d;

  logic          nonempty;
  logic          head_owner;
  logic [DW-1:0] head_data;
  logic          pop;
  logic          push;
  logic [2:0]    occ;
  logic          free;
  logic          grant;
  logic          win_m1;

  always_comb begin
    nonempty   = (count_q != 2'd0);
    head_owner = fifo_owner_q[rd_ptr_q];
    head_data  = fifo_data_q[rd_ptr_q];
    pop        = nonempty & (head_owner ? m1_rsp_ready : m0_rsp_ready);
    push       = a_valid_q;

    // Slot accounting includes this cycle's pop, so rsp_ready feeds req_ready directly.
    occ  = {1'b0, count_q} - {2'b00, pop} + {2'b00, a_valid_q};
    free = (occ < 3'd2);

    win_m1 = m1_req_valid & (~m0_req_valid | ~last_grant_q);
    grant  = free & ~rst & (m0_req_valid | m1_req_valid);

    m0_req_ready = grant & ~win_m1;
    m1_req_ready = grant & win_m1;

    mem_en    = grant;
    mem_we    = grant & win_m1 & m1_we;
    mem_addr  = win_m1 ? m1_addr : m0_addr;
    mem_wdata = win_m1 ? m1_wdata : '0;

    m0_rsp_valid = nonempty & ~head_owner;
    m1_rsp_valid = nonempty & head_owner;
    m0_rsp_data  = m0_rsp_valid ? head_data : '0;
    m1_rsp_data  = m1_rsp_valid ? head_data : '0;

    a_valid_d = grant;
    a_owner_d = grant ? win_m1 : a_owner_q;
    a_we_d    = grant ? (win_m1 & m1_we) : a_we_q;

    fifo_owner_d = fifo_owner_q;
    fifo_data_d  = fifo_data_q;
    if (push) begin
      fifo_owner_d[wr_ptr_q] = a_owner_q;
      fifo_data_d[wr_ptr_q]  = a_we_q ? '0 : mem_rdata;
    end

    wr_ptr_d     = wr_ptr_q ^ push;
    rd_ptr_d     = rd_ptr_q ^ pop;
    count_d      = count_q + {1'b0, push} - {1'b0, pop};
    last_grant_d = grant ? win_m1 : last_grant_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q    <= 1'b0;
      a_owner_q    <= 1'b0;
      a_we_q       <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_owner_q[i] <= 1'b0;
        fifo_data_q[i]  <= '0;
      end
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      last_grant_q <= 1'b1;
    end else begin
      a_valid_q    <= a_valid_d;
      a_owner_q    <= a_owner_d;
      a_we_q       <= a_we_d;
      fifo_owner_q <= fifo_owner_d;
      fifo_data_q  <= fifo_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter that shares the single-port instruction memory between the core fetch port (m0, read-only) and a loader/debug port (m1, read/write). It round-robins between requesters and issues at most one memory access per cycle to a synchronous 1-cycle-latency memory. Read data and write acknowledges return in order through a 2-entry response FIFO. It sits between the core / loader and the memory inside the SoC top.

## Interface
- AW, 32, address width (byte address, passed through unchanged)
- DW, 32, data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req_valid  in  1  core fetch request
- m0_req_ready  out  1  core request accepted this cycle
- m0_addr  in  AW  fetch address
- m0_rsp_valid  out  1  fetch response present
- m0_rsp_ready  in  1  core takes response
- m0_rsp_data  out  DW  fetched instruction
- m1_req_valid  in  1  loader request
- m1_req_ready  out  1  loader request accepted
- m1_we  in  1  1 = write, 0 = read
- m1_addr  in  AW  loader address
- m1_wdata  in  DW  write data
- m1_rsp_valid  out  1  loader response present (read data or write ack)
- m1_rsp_ready  in  1  loader takes response
- m1_rsp_data  out  DW  read data; 0 for write acks
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  valid in the cycle after a read (mem_en=1, mem_we=0)

## Operation
- State:
  - in-flight register A: {valid, owner, we}
  - response FIFO: 2 entries of {owner, data}, with wr/rd pointers and a 2-bit count
  - last_grant: 1 bit
- Slot free in cycle t: free = (count − pop + A.valid) < 2.
  - pop = FIFO non-empty AND the head owner's rsp_ready.
  - This gives a combinational path rsp_ready → req_ready. That path is intentional.
- Grant, only when free:
  - Only one port valid: that port wins.
  - Both valid: the port ≠ last_grant wins.
  - last_grant updates to the winner on every grant.
- On grant in cycle t:
  - Winner's req_ready=1 combinationally.
  - mem_en=1, and mem_addr/mem_we/mem_wdata are muxed from the winner. m0 always drives mem_we=0.
  - At end of t: A ← {1, winner, we}.
- Cycle t+1, A.valid: push {A.owner, A.we ? 0 : mem_rdata} into the FIFO. A clears unless a new grant occurs.
- FIFO head drives the response ports:
  - m0_rsp_valid = nonempty & head.owner==0; m1_rsp_valid = nonempty & head.owner==1.
  - rsp_data is the head data on both ports, shown to the owner only.
- Responses are strictly in grant order. A non-ready head owner blocks the other port's response (head-of-line blocking; accepted).
- Push and pop in the same cycle are both performed; count is unchanged.
- No request is dropped; a requester holds valid/addr/data until it sees ready.

## Timing
- Reset values: A.valid=0, FIFO empty (count=0, pointers 0), last_grant=1 (m0 wins the first tie).
- Outputs during reset: m0_rsp_valid=0, m1_rsp_valid=0, rsp_data=0, mem_en=0.
- Latency: request accepted in cycle t → rsp_valid in cycle t+2 at the earliest (FIFO written at end of t+1).
- Throughput: 1 access/cycle sustained while the consumer keeps rsp_ready=1.
- Both ports continuously valid, all rsp_ready=1: grants alternate m0, m1, m0, …
- FIFO full (count=2), no pop: free=0, both req_ready=0, mem_en=0.
- count=1, A.valid=1, pop=0: no grant. The pending A result fills the second entry next cycle.
- Reset asserted mid-operation: in-flight and buffered responses are discarded; mem_en drops immediately (asynchronous).

## Test plan
- Single fetch: m0 read 0x0000_0004, mem returns 0x0010_0093 → m0_req_ready in t, m0_rsp_valid in t+2 with 0x0010_0093; m1_rsp_valid stays 0.
- Contention: m0 and m1 both valid for 6 cycles, rsp_ready=1 → grant order m0, m1, m0, m1, m0, m1; mem_en high all 6 cycles; responses in the same order.
- Loader write then fetch: m1 writes 0xDEAD_BEEF to 0x8, then m0 reads 0x8 → m1 ack with data 0; m0 receives 0xDEAD_BEEF.
- Backpressure: m0 streams reads with m0_rsp_ready=0 → exactly 2 requests accepted, then m0_req_ready=0 and mem_en=0. Raising ready drains 2 responses in order and grants resume in the same cycle.
- Head-of-line: m0 response at head with m0_rsp_ready=0, m1 response behind it → m1_rsp_valid=0 until m0 pops.
- Reset mid-stream: assert rst while count=2 and A.valid=1 → next cycle all rsp_valid=0 and mem_en=0; the first request after reset gets a clean t+2 response.
